// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: decoder control word
// layout, opcode and ALUOp encodings.
package mips_pkg;

  // Decoder control word, MSB first, same bit order as id_ctrl / ex_ctrl.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       branch;
    logic       branch_neq;
    logic       alu_src;
    logic       mem_write;
    logic       reg_write;
    logic       jump;
    logic       lui;
    logic       pad;
  } ctrl_t;

  // All-zero control word: no register, memory or PC side effects.
  localparam ctrl_t CTRL_NOP = ctrl_t'(13'h0000);

  // Primary opcode field values.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALUOp encodings consumed by the ALU controller in EX.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

endpackage : mips_pkg

// File: rtl/id_hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the
// destination register of a load currently sitting in EX.
module id_hazard_detect (
  input  logic       i_id_valid,
  input  logic       i_id_lui,
  input  logic       i_id_jump,
  input  logic       i_id_reg_dst,
  input  logic       i_id_branch,
  input  logic       i_id_branch_neq,
  input  logic       i_id_mem_write,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_ex_valid,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rt,
  output logic       o_uses_rs,
  output logic       o_uses_rt,
  output logic       o_load_use
);

  logic w_rs_match;
  logic w_rt_match;
  logic w_ex_is_load;

  // Operand usage and register match; $zero never creates a dependency.
  always_comb begin
    o_uses_rs    = ~(i_id_lui | i_id_jump);
    o_uses_rt    = i_id_reg_dst | i_id_branch | i_id_branch_neq | i_id_mem_write;
    w_ex_is_load = i_ex_valid & i_ex_mem_read & (i_ex_rt != 5'd0);
    w_rs_match   = o_uses_rs & (i_id_rs == i_ex_rt);
    w_rt_match   = o_uses_rt & (i_id_rt == i_ex_rt);
    if (w_ex_is_load && i_id_valid) begin
      o_load_use = w_rs_match | w_rt_match;
    end else begin
      o_load_use = 1'b0;
    end
  end

endmodule : id_hazard_detect

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoder control and operands into EX,
// stalls IF/ID on load-use, inserts bubbles on hazard or flush and keeps
// saturating bubble/flush counters.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [12:0]      id_ctrl,
  input  logic [DW-1:0]    id_pc4,
  input  logic [DW-1:0]    id_rs_data,
  input  logic [DW-1:0]    id_rt_data,
  input  logic [DW-1:0]    id_imm,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [5:0]       id_funct,
  input  logic             ex_hold,
  input  logic             flush,
  output logic             ex_valid,
  output logic [12:0]      ex_ctrl,
  output logic [DW-1:0]    ex_pc4,
  output logic [DW-1:0]    ex_rs_data,
  output logic [DW-1:0]    ex_rt_data,
  output logic [DW-1:0]    ex_imm,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [5:0]       ex_funct,
  output logic             stall_if_id,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ctrl_t w_id_ctrl;
  logic  w_uses_rs;
  logic  w_uses_rt;
  logic  w_load_use;

  logic             r_ex_valid;
  ctrl_t            r_ex_ctrl;
  logic [DW-1:0]    r_ex_pc4;
  logic [DW-1:0]    r_ex_rs_data;
  logic [DW-1:0]    r_ex_rt_data;
  logic [DW-1:0]    r_ex_imm;
  logic [4:0]       r_ex_rs;
  logic [4:0]       r_ex_rt;
  logic [4:0]       r_ex_rd;
  logic [5:0]       r_ex_funct;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_id_ctrl = ctrl_t'(id_ctrl);

  id_hazard_detect u_hazard (
    .i_id_valid      (id_valid),
    .i_id_lui        (w_id_ctrl.lui),
    .i_id_jump       (w_id_ctrl.jump),
    .i_id_reg_dst    (w_id_ctrl.reg_dst),
    .i_id_branch     (w_id_ctrl.branch),
    .i_id_branch_neq (w_id_ctrl.branch_neq),
    .i_id_mem_write  (w_id_ctrl.mem_write),
    .i_id_rs         (id_rs),
    .i_id_rt         (id_rt),
    .i_ex_valid      (r_ex_valid),
    .i_ex_mem_read   (r_ex_ctrl.mem_read),
    .i_ex_rt         (r_ex_rt),
    .o_uses_rs       (w_uses_rs),
    .o_uses_rt       (w_uses_rt),
    .o_load_use      (w_load_use)
  );

  // Freeze PC and IF/ID on a load-use or downstream hold; a flush discards
  // the ID instruction anyway, so it never stalls.
  assign stall_if_id = (w_load_use | ex_hold) & ~flush;

  // EX register bank: flush > hold > load-use bubble > normal advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid   <= 1'b0;
      r_ex_ctrl    <= CTRL_NOP;
      r_ex_pc4     <= {DW{1'b0}};
      r_ex_rs_data <= {DW{1'b0}};
      r_ex_rt_data <= {DW{1'b0}};
      r_ex_imm     <= {DW{1'b0}};
      r_ex_rs      <= 5'd0;
      r_ex_rt      <= 5'd0;
      r_ex_rd      <= 5'd0;
      r_ex_funct   <= 6'd0;
      r_bubble_cnt <= {CNT_W{1'b0}};
      r_flush_cnt  <= {CNT_W{1'b0}};
    end else if (flush || (!ex_hold && w_load_use)) begin
      // Bubble: a fully zeroed slot is architecturally a nop.
      r_ex_valid   <= 1'b0;
      r_ex_ctrl    <= CTRL_NOP;
      r_ex_pc4     <= {DW{1'b0}};
      r_ex_rs_data <= {DW{1'b0}};
      r_ex_rt_data <= {DW{1'b0}};
      r_ex_imm     <= {DW{1'b0}};
      r_ex_rs      <= 5'd0;
      r_ex_rt      <= 5'd0;
      r_ex_rd      <= 5'd0;
      r_ex_funct   <= 6'd0;
      if (flush) begin
        if (id_valid && (r_flush_cnt != CNT_MAX)) begin
          r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end else begin
          r_flush_cnt <= r_flush_cnt;
        end
      end else begin
        if (r_bubble_cnt != CNT_MAX) begin
          r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
        end else begin
          r_bubble_cnt <= r_bubble_cnt;
        end
      end
    end else if (ex_hold) begin
      r_ex_valid <= r_ex_valid;
    end else begin
      // Invalid slots carry data but never a control side effect.
      r_ex_valid   <= id_valid;
      r_ex_ctrl    <= id_valid ? w_id_ctrl : CTRL_NOP;
      r_ex_pc4     <= id_pc4;
      r_ex_rs_data <= id_rs_data;
      r_ex_rt_data <= id_rt_data;
      r_ex_imm     <= id_imm;
      r_ex_rs      <= id_rs;
      r_ex_rt      <= id_rt;
      r_ex_rd      <= id_rd;
      r_ex_funct   <= id_funct;
    end
  end

  assign ex_valid   = r_ex_valid;
  assign ex_ctrl    = r_ex_ctrl;
  assign ex_pc4     = r_ex_pc4;
  assign ex_rs_data = r_ex_rs_data;
  assign ex_rt_data = r_ex_rt_data;
  assign ex_imm     = r_ex_imm;
  assign ex_rs      = r_ex_rs;
  assign ex_rt      = r_ex_rt;
  assign ex_rd      = r_ex_rd;
  assign ex_funct   = r_ex_funct;
  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table walked one cycle per row,
// then hand-written reset and counter-saturation sequences. A second
// instance with 3-bit counters shares the stimulus to reach saturation fast.
module tb_id_ex_stage;

  localparam logic [12:0] C_ADDI = 13'h0028;
  localparam logic [12:0] C_LW   = 13'h0628;
  localparam logic [12:0] C_ADD  = 13'h1108;
  localparam logic [12:0] C_LUI  = 13'h002A;
  localparam logic [12:0] C_SW   = 13'h0030;
  localparam logic [12:0] C_BEQ  = 13'h0880;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [12:0] id_ctrl = 13'h0;
  logic [31:0] id_pc4 = 32'h0, id_rs_data = 32'h0, id_rt_data = 32'h0, id_imm = 32'h0;
  logic [4:0]  id_rs = 5'd0, id_rt = 5'd0, id_rd = 5'd0;
  logic [5:0]  id_funct = 6'd0;
  logic        ex_hold = 1'b0, flush = 1'b0;

  logic        ex_valid, stall_if_id;
  logic [12:0] ex_ctrl;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [5:0]  ex_funct;
  logic [15:0] bubble_cnt, flush_cnt;

  logic        s_ex_valid, s_stall;
  logic [12:0] s_ex_ctrl;
  logic [31:0] s_pc4, s_rs_data, s_rt_data, s_imm;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [5:0]  s_funct;
  logic [2:0]  s_bubble_cnt, s_flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_funct(id_funct), .ex_hold(ex_hold), .flush(flush),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .stall_if_id(stall_if_id), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.DW(32), .CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_funct(id_funct), .ex_hold(ex_hold), .flush(flush),
    .ex_valid(s_ex_valid), .ex_ctrl(s_ex_ctrl), .ex_pc4(s_pc4),
    .ex_rs_data(s_rs_data), .ex_rt_data(s_rt_data), .ex_imm(s_imm),
    .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .ex_funct(s_funct),
    .stall_if_id(s_stall), .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct {
    logic        valid;
    logic [12:0] ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic        hold, fl;
    logic        exp_stall;
    logic        exp_valid;
    logic [12:0] exp_ctrl;
    int          exp_src;   // row whose ID fields should be in EX, -1 = zeros
    int          exp_b, exp_f;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(logic v, logic [12:0] c, logic [4:0] rs, logic [4:0] rt,
                              logic [4:0] rd, logic [31:0] imm, logic h, logic f,
                              logic es, logic ev, logic [12:0] ec, int src, int b, int fc);
    vec_t r;
    r.valid = v; r.ctrl = c; r.rs = rs; r.rt = rt; r.rd = rd; r.imm = imm;
    r.hold = h; r.fl = f; r.exp_stall = es; r.exp_valid = ev; r.exp_ctrl = ec;
    r.exp_src = src; r.exp_b = b; r.exp_f = fc;
    return r;
  endfunction

  function automatic logic [31:0] pc4_of(int i);
    return 32'h0040_0000 + 32'(i) * 32'd4;
  endfunction

  function automatic logic [31:0] rsd_of(int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  function automatic logic [31:0] rtd_of(int i);
    return 32'hB000_0000 | 32'(i);
  endfunction

  function automatic logic [5:0] funct_of(int i);
    return 6'(i) + 6'h20;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [12:0] c, logic [4:0] rs, logic [4:0] rt,
                       logic [4:0] rd, logic [31:0] imm, logic h, logic f, int idx);
    id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd; id_imm = imm;
    ex_hold = h; flush = f;
    id_pc4 = pc4_of(idx); id_rs_data = rsd_of(idx); id_rt_data = rtd_of(idx);
    id_funct = funct_of(idx);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    int   s;
    //            v     ctrl    rs     rt     rd     imm         h     f     stall ev    ectrl   src b  f
    vecs[0]  = mk(1'b1, C_ADDI, 5'd1,  5'd2,  5'd0,  32'h5,      1'b0, 1'b0, 1'b0, 1'b1, C_ADDI, 0,  0, 0);
    vecs[1]  = mk(1'b1, C_LW,   5'd1,  5'd8,  5'd0,  32'h4,      1'b0, 1'b0, 1'b0, 1'b1, C_LW,   1,  0, 0);
    vecs[2]  = mk(1'b1, C_ADD,  5'd8,  5'd3,  5'd4,  32'h0,      1'b0, 1'b0, 1'b1, 1'b0, 13'h0,  -1, 1, 0);
    vecs[3]  = mk(1'b1, C_ADD,  5'd8,  5'd3,  5'd4,  32'h0,      1'b0, 1'b0, 1'b0, 1'b1, C_ADD,  3,  1, 0);
    vecs[4]  = mk(1'b1, C_LW,   5'd2,  5'd0,  5'd0,  32'h8,      1'b0, 1'b0, 1'b0, 1'b1, C_LW,   4,  1, 0);
    vecs[5]  = mk(1'b1, C_ADD,  5'd0,  5'd0,  5'd5,  32'h0,      1'b0, 1'b0, 1'b0, 1'b1, C_ADD,  5,  1, 0);
    vecs[6]  = mk(1'b1, C_LW,   5'd1,  5'd9,  5'd0,  32'hC,      1'b0, 1'b0, 1'b0, 1'b1, C_LW,   6,  1, 0);
    vecs[7]  = mk(1'b1, C_LUI,  5'd9,  5'd9,  5'd0,  32'h1234,   1'b0, 1'b0, 1'b0, 1'b1, C_LUI,  7,  1, 0);
    vecs[8]  = mk(1'b1, C_LW,   5'd1,  5'd9,  5'd0,  32'h10,     1'b0, 1'b0, 1'b0, 1'b1, C_LW,   8,  1, 0);
    vecs[9]  = mk(1'b1, C_ADDI, 5'd3,  5'd9,  5'd0,  32'h1,      1'b0, 1'b0, 1'b0, 1'b1, C_ADDI, 9,  1, 0);
    vecs[10] = mk(1'b1, C_LW,   5'd1,  5'd7,  5'd0,  32'h14,     1'b0, 1'b0, 1'b0, 1'b1, C_LW,   10, 1, 0);
    vecs[11] = mk(1'b1, C_SW,   5'd1,  5'd7,  5'd0,  32'h0,      1'b0, 1'b0, 1'b1, 1'b0, 13'h0,  -1, 2, 0);
    vecs[12] = mk(1'b1, C_SW,   5'd1,  5'd7,  5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 1'b1, C_SW,   12, 2, 0);
    vecs[13] = mk(1'b1, C_LW,   5'd1,  5'd5,  5'd0,  32'h18,     1'b0, 1'b0, 1'b0, 1'b1, C_LW,   13, 2, 0);
    vecs[14] = mk(1'b1, C_BEQ,  5'd5,  5'd6,  5'd0,  32'h3,      1'b0, 1'b1, 1'b0, 1'b0, 13'h0,  -1, 2, 1);
    vecs[15] = mk(1'b0, C_ADD,  5'd1,  5'd2,  5'd3,  32'h3,      1'b0, 1'b0, 1'b0, 1'b0, 13'h0,  15, 2, 1);
    vecs[16] = mk(1'b0, C_ADD,  5'd1,  5'd2,  5'd3,  32'h3,      1'b0, 1'b1, 1'b0, 1'b0, 13'h0,  -1, 2, 1);
    vecs[17] = mk(1'b1, C_LW,   5'd1,  5'd6,  5'd0,  32'h1C,     1'b0, 1'b0, 1'b0, 1'b1, C_LW,   17, 2, 1);
    vecs[18] = mk(1'b1, C_BEQ,  5'd1,  5'd6,  5'd0,  32'h2,      1'b1, 1'b0, 1'b1, 1'b1, C_LW,   17, 2, 1);
    vecs[19] = mk(1'b1, C_BEQ,  5'd1,  5'd6,  5'd0,  32'h2,      1'b1, 1'b0, 1'b1, 1'b1, C_LW,   17, 2, 1);
    vecs[20] = mk(1'b1, C_BEQ,  5'd1,  5'd6,  5'd0,  32'h2,      1'b1, 1'b0, 1'b1, 1'b1, C_LW,   17, 2, 1);
    vecs[21] = mk(1'b1, C_BEQ,  5'd1,  5'd6,  5'd0,  32'h2,      1'b0, 1'b0, 1'b1, 1'b0, 13'h0,  -1, 3, 1);
    vecs[22] = mk(1'b1, C_BEQ,  5'd1,  5'd6,  5'd0,  32'h2,      1'b0, 1'b0, 1'b0, 1'b1, C_BEQ,  22, 3, 1);
    vecs[23] = mk(1'b1, C_ADDI, 5'd6,  5'd1,  5'd0,  32'h7,      1'b1, 1'b0, 1'b1, 1'b1, C_BEQ,  22, 3, 1);
    vecs[24] = mk(1'b1, C_ADDI, 5'd6,  5'd1,  5'd0,  32'h7,      1'b1, 1'b1, 1'b0, 1'b0, 13'h0,  -1, 3, 2);

    // Reset state, then release away from the clock edge.
    drive(1'b0, 13'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 32'h0);
    chk("rst_bubble_cnt", 32'(bubble_cnt), 32'h0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'h0);
    rst_n = 1'b1;

    // Table walk: check stall before the edge, EX contents after it.
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      drive(v.valid, v.ctrl, v.rs, v.rt, v.rd, v.imm, v.hold, v.fl, i);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall_if_id), 32'(v.exp_stall));
      @(posedge clk);
      #1;
      s = v.exp_src;
      chk($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(v.exp_valid));
      chk($sformatf("v%0d_ex_ctrl", i), 32'(ex_ctrl), 32'(v.exp_ctrl));
      chk($sformatf("v%0d_ex_pc4", i), ex_pc4, (s < 0) ? 32'h0 : pc4_of(s));
      chk($sformatf("v%0d_ex_rs_data", i), ex_rs_data, (s < 0) ? 32'h0 : rsd_of(s));
      chk($sformatf("v%0d_ex_rt_data", i), ex_rt_data, (s < 0) ? 32'h0 : rtd_of(s));
      chk($sformatf("v%0d_ex_imm", i), ex_imm, (s < 0) ? 32'h0 : vecs[s].imm);
      chk($sformatf("v%0d_ex_rs", i), 32'(ex_rs), (s < 0) ? 32'h0 : 32'(vecs[s].rs));
      chk($sformatf("v%0d_ex_rt", i), 32'(ex_rt), (s < 0) ? 32'h0 : 32'(vecs[s].rt));
      chk($sformatf("v%0d_ex_rd", i), 32'(ex_rd), (s < 0) ? 32'h0 : 32'(vecs[s].rd));
      chk($sformatf("v%0d_ex_funct", i), 32'(ex_funct), (s < 0) ? 32'h0 : 32'(funct_of(s)));
      chk($sformatf("v%0d_bubble_cnt", i), 32'(bubble_cnt), 32'(v.exp_b));
      chk($sformatf("v%0d_flush_cnt", i), 32'(flush_cnt), 32'(v.exp_f));
    end

    // Asynchronous reset mid-run with a valid instruction in EX.
    drive(1'b1, C_ADDI, 5'd1, 5'd2, 5'd3, 32'h5, 1'b0, 1'b0, 40);
    tick();
    chk("pre_rst_ex_valid", 32'(ex_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ex_valid", 32'(ex_valid), 32'h0);
    chk("arst_ex_ctrl", 32'(ex_ctrl), 32'h0);
    chk("arst_ex_imm", ex_imm, 32'h0);
    chk("arst_ex_pc4", ex_pc4, 32'h0);
    chk("arst_ex_rt", 32'(ex_rt), 32'h0);
    chk("arst_bubble_cnt", 32'(bubble_cnt), 32'h0);
    chk("arst_flush_cnt", 32'(flush_cnt), 32'h0);
    chk("arst_s_bubble_cnt", 32'(s_bubble_cnt), 32'h0);
    chk("arst_stall", 32'(stall_if_id), 32'h0);
    @(negedge clk);
    drive(1'b0, 13'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 0);
    rst_n = 1'b1;
    tick();

    // Nine load-use pairs: one bubble each; 3-bit counter must stick at 7.
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, C_LW, 5'd1, 5'd4, 5'd0, 32'h0, 1'b0, 1'b0, 50);
      tick();
      drive(1'b1, C_ADD, 5'd4, 5'd2, 5'd3, 32'h0, 1'b0, 1'b0, 51);
      tick();
      tick();
    end
    chk("sat_bubble_cnt16", 32'(bubble_cnt), 32'd9);
    chk("sat_bubble_cnt3", 32'(s_bubble_cnt), 32'd7);
    chk("sat_ex_ctrl", 32'(ex_ctrl), 32'(C_ADD));

    // Nine flushes of valid instructions: 3-bit counter must stick at 7.
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, C_ADDI, 5'd1, 5'd2, 5'd0, 32'h1, 1'b0, 1'b1, 60);
      tick();
    end
    chk("sat_flush_cnt16", 32'(flush_cnt), 32'd9);
    chk("sat_flush_cnt3", 32'(s_flush_cnt), 32'd7);
    chk("sat_bubble_keep", 32'(bubble_cnt), 32'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_id_ex_stage
